// File: rtl/kernel_buffer_loader.sv
// rtl/kernel_buffer_loader.sv - write-side sequencer filling kernel buffer banks row by row
// Optional abort input enabled by KERNEL_BUFFER_LOADER_ABORT_EN.
module kernel_buffer_loader #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [A-1:0]         baseAddress,
  input  logic [A:0]           rowCount,
  input  logic [W-1:0]         inData,
  input  logic                 inValid,
`ifdef KERNEL_BUFFER_LOADER_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 inReady,
  output logic [A-1:0]         address,
  output logic [W+depth+1:0]   ioInputs,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [A-1:0]     r_base;
  logic [A:0]       r_rows;
  logic [A:0]       r_row;
  logic [depth-1:0] r_bank;
  logic             r_sel;
  logic             r_wr;
  logic [depth-1:0] r_bank_sel;
  logic [W-1:0]     r_data;
  logic [A-1:0]     r_address;
  logic             r_busy;
  logic             r_done;
  logic             w_abort;
  logic             w_accept;
  logic             w_last_bank;
  logic             w_last_word;

`ifdef KERNEL_BUFFER_LOADER_ABORT_EN
  assign w_abort = abort & (r_state == S_LOAD);
`else
  assign w_abort = 1'b0;
`endif

  assign inReady     = (r_state == S_LOAD);
  // A word offered in the abort cycle is dropped rather than written.
  assign w_accept    = inReady & inValid & ~w_abort;
  assign w_last_bank = &r_bank;
  assign w_last_word = w_last_bank && (r_row == (r_rows - (A+1)'(1)));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (rowCount == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (w_abort)                     w_next = S_IDLE;
        else if (w_accept && w_last_word) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_base <= '0;
      r_rows <= '0;
      r_row  <= '0;
      r_bank <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_base <= baseAddress;
      r_rows <= rowCount;
      r_row  <= '0;
      r_bank <= '0;
    end else if (w_accept) begin
      r_bank <= r_bank + depth'(1);
      if (w_last_bank) r_row <= r_row + (A+1)'(1);
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sel      <= 1'b0;
      r_wr       <= 1'b0;
      r_bank_sel <= '0;
      r_data     <= '0;
      r_address  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sel  <= (w_next != S_IDLE);
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      r_wr   <= w_accept;
      if (w_accept) begin
        r_data     <= inData;
        r_bank_sel <= r_bank;
        r_address  <= r_base + r_row[A-1:0];
      end
    end
  end

  assign address  = r_address;
  assign ioInputs = {r_sel, r_wr, r_bank_sel, r_data};
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_kernel_buffer_loader.sv
// tb/tb_kernel_buffer_loader.sv - randomized self-checking bench for kernel_buffer_loader
// Abort scenario is compiled only with KERNEL_BUFFER_LOADER_ABORT_EN.
module tb_kernel_buffer_loader;
  localparam int DEPTH = 2;
  localparam int A     = 7;
  localparam int W     = 16;
  localparam int D     = 1 << DEPTH;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 start = 1'b0;
  logic [A-1:0]         baseAddress = '0;
  logic [A:0]           rowCount = '0;
  logic [W-1:0]         inData = '0;
  logic                 inValid = 1'b0;
  logic                 abort = 1'b0;
  logic                 inReady;
  logic [A-1:0]         address;
  logic [W+DEPTH+1:0]   ioInputs;
  logic                 busy;
  logic                 done;

  wire                  w_io_select = ioInputs[W+DEPTH+1];
  wire                  w_io_write  = ioInputs[W+DEPTH];
  wire [DEPTH-1:0]      w_io_bank   = ioInputs[W+DEPTH-1 -: DEPTH];
  wire [W-1:0]          w_io_data   = ioInputs[W-1:0];

  always #5 CLK = ~CLK;

  kernel_buffer_loader #(.depth(DEPTH), .A(A), .W(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .baseAddress (baseAddress),
    .rowCount    (rowCount),
    .inData      (inData),
    .inValid     (inValid),
`ifdef KERNEL_BUFFER_LOADER_ABORT_EN
    .abort       (abort),
`endif
    .inReady     (inReady),
    .address     (address),
    .ioInputs    (ioInputs),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int addr;
    int bank;
    int data;
  } wr_t;

  wr_t exp_q[$];
  bit  mon_en     = 1'b0;
  bit  seen_write = 1'b0;
  int  last_addr  = 0;
  int  last_bank  = 0;

  always @(negedge CLK) begin
    if (mon_en) begin
      wr_t e;
      check("iosel_vs_busy", w_io_select, busy);
      if (w_io_write) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", address, e.addr);
          check("wr_bank", w_io_bank, e.bank);
          check("wr_data", w_io_data, e.data);
          last_addr  = e.addr;
          last_bank  = e.bank;
          seen_write = 1'b1;
        end
      end else if (busy && seen_write) begin
        check("hold_addr", address, last_addr);
        check("hold_bank", w_io_bank, last_bank);
      end
    end
  end

  // stop_after < 0 runs the full load; otherwise return right after that many words.
  task automatic do_load(input int base, input int rows, input int stall_pct,
                         input bit seq, input int stop_after);
    int words[$];
    int n, n_exp, idx, cyc, w;
    bit hs;
    n = rows * D;
    n_exp = (stop_after >= 0) ? stop_after : n;
    for (int i = 0; i < n; i++) begin
      w = seq ? i + 1 : int'($urandom_range(0, 65535));
      words.push_back(w);
      if (i < n_exp) exp_q.push_back('{(base + i / D) % (1 << A), i % D, w});
    end
    @(negedge CLK);
    seen_write  = 1'b0;
    start       = 1'b1;
    baseAddress = A'(base);
    rowCount    = (A+1)'(rows);
    @(negedge CLK);
    start = 1'b0;
    check("inready_after_start", inReady, rows != 0);
    check("busy_after_start", busy, 1);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000 && !(stop_after >= 0 && idx >= stop_after)) begin
      inValid     = ($urandom_range(0, 99) >= stall_pct);
      inData      = W'(words[idx]);
      start       = 1'($urandom_range(0, 1));
      baseAddress = A'($urandom_range(0, 127));
      rowCount    = (A+1)'($urandom_range(0, 255));
      hs = inValid && inReady;
      @(negedge CLK);
      if (hs) idx++;
      cyc++;
    end
    inValid = 1'b0;
    start   = 1'b0;
    if (cyc >= 2000) check("load_timeout", idx, n);
    if (stop_after < 0) begin
      check("done_pulse", done, 1);
      check("done_with_write", w_io_write, n != 0);
      check("done_inready", inReady, 0);
      @(negedge CLK);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_select", w_io_select, 0);
      check("idle_inready", inReady, 0);
      check("exp_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_address", address, 0);
    check("rst_ioinputs", ioInputs, 0);
    check("rst_inready", inReady, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    RST    = 1'b0;
    mon_en = 1'b1;

    do_load(5, 2, 0, 1'b1, -1);
    do_load(9, 3, 60, 1'b0, -1);
    do_load(127, 2, 30, 1'b0, -1);
    do_load(40, 0, 0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      do_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 70)), 1'b0, -1);
    end

    do_load(20, 2, 0, 1'b0, 3);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_address", address, 0);
    check("midrst_ioinputs", ioInputs, 0);
    check("midrst_inready", inReady, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_exp_drained", exp_q.size(), 0);
    RST = 1'b0;
    do_load(10, 1, 0, 1'b0, -1);

`ifdef KERNEL_BUFFER_LOADER_ABORT_EN
    do_load(3, 1, 0, 1'b0, 2);
    abort   = 1'b1;
    inValid = 1'b1;
    inData  = 16'hBEEF;
    @(negedge CLK);
    abort   = 1'b0;
    inValid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_write", w_io_write, 0);
    check("abort_inready", inReady, 0);
    @(negedge CLK);
    check("abort_done_later", done, 0);
    check("abort_exp_drained", exp_q.size(), 0);
`endif

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
